// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : cpu_bus_pkg                                                    |
// | Purpose  : Shared CPU-side SRAM-like bus definitions: requester IDs,      |
// |            access-size encodings, bus width and the request bundle used   |
// |            to mux requesters onto one port.                               |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package cpu_bus_pkg;

  localparam int unsigned XLEN = 32;

  // Requester identifiers stored in the order FIFO
  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  // Access-size encodings
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // All request fields that travel together with req
  typedef struct packed {
    logic            wr;
    logic [1:0]      size;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/order_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : order_fifo                                                     |
// | Purpose  : Small circular FIFO holding requester IDs in issue order.      |
// | Ports    : clk, resetn (sync, active-low)                                 |
// |            push_i/din_i  - enqueue (ignored while full)                   |
// |            pop_i         - dequeue (ignored while empty)                  |
// |            head_o        - oldest entry (registered storage)              |
// |            full_o/empty_o- occupancy flags from the count register        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module order_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W     = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i  & ~empty_o;
  assign head_o  = entries_q[rd_ptr_q];

  // Pointers wrap explicitly so non-power-of-two depths work
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid
  always_ff @(posedge clk) begin
    if (push_ok) entries_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_req_arbiter                                               |
// | Purpose  : Shares one SRAM-like port between instruction fetch and data   |
// |            access. Data wins when both request; a grant lock keeps a      |
// |            stalled request stable until accepted. Responses are steered   |
// |            back using an in-order FIFO of requester IDs.                  |
// | Ports    : clk, resetn (sync, active-low)                                 |
// |            inst_* / data_*  - requester sides (req fields in, handshake   |
// |                               and read data out)                          |
// |            mem_*            - shared port (request out, handshake and     |
// |                               response in)                                |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sram_req_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [3:0]      inst_wstrb,
  input  logic [XLEN-1:0] inst_addr,
  input  logic [XLEN-1:0] inst_wdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [XLEN-1:0] inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [3:0]      data_wstrb,
  input  logic [XLEN-1:0] data_addr,
  input  logic [XLEN-1:0] data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [XLEN-1:0] data_rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [XLEN-1:0] mem_rdata
);

  bus_req_t inst_bus, data_bus, gnt_bus;
  logic     grant_lock_q, grant_lock_d;
  logic     grant_id_q,   grant_id_d;
  logic     grant_id;
  logic     gnt_req;
  logic     handshake;
  logic     resp_valid;
  logic     fifo_full, fifo_empty;
  logic     fifo_head;

  assign inst_bus = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                      addr: inst_addr, wdata: inst_wdata};
  assign data_bus = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

  // While locked the stalled requester keeps the port regardless of priority
  assign grant_id = grant_lock_q ? grant_id_q : (data_req ? REQ_DATA : REQ_INST);
  assign gnt_req  = (grant_id == REQ_DATA) ? data_req : inst_req;
  assign gnt_bus  = (grant_id == REQ_DATA) ? data_bus : inst_bus;

  // Full is taken from the registered count only, so a same-cycle pop cannot
  // reopen the port: no combinational path from mem_data_ok to mem_req.
  assign mem_req   = resetn & gnt_req & ~fifo_full;
  assign mem_wr    = gnt_bus.wr;
  assign mem_size  = gnt_bus.size;
  assign mem_wstrb = gnt_bus.wstrb;
  assign mem_addr  = gnt_bus.addr;
  assign mem_wdata = gnt_bus.wdata;

  assign handshake    = mem_req & mem_addr_ok;
  assign inst_addr_ok = handshake & (grant_id == REQ_INST);
  assign data_addr_ok = handshake & (grant_id == REQ_DATA);

  // Responses with nothing outstanding are dropped
  assign resp_valid   = resetn & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_valid & (fifo_head == REQ_INST);
  assign data_data_ok = resp_valid & (fifo_head == REQ_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    grant_lock_d = grant_lock_q;
    grant_id_d   = grant_id_q;
    if (!grant_lock_q) begin
      if (mem_req && !mem_addr_ok) begin
        grant_lock_d = 1'b1;
        grant_id_d   = grant_id;
      end
    end else if (handshake) begin
      grant_lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_lock_q <= 1'b0;
      grant_id_q   <= REQ_INST;
    end else begin
      grant_lock_q <= grant_lock_d;
      grant_id_q   <= grant_id_d;
    end
  end

  order_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (handshake),
    .pop_i   (resp_valid),
    .din_i   (grant_id),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_req_arbiter                                            |
// | Purpose  : Self-checking bench for sram_req_arbiter. Two instances share  |
// |            stimulus: u_dut2 (OUTSTANDING=2) and u_dut4 (OUTSTANDING=4).   |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sram_req_arbiter;

  localparam logic [31:0] IA  = 32'h1C00_0000;
  localparam logic [31:0] DA  = 32'h8000_1000;
  localparam logic [31:0] IWD = 32'h0000_0000;
  localparam logic [31:0] DWD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        i_aok2, i_dok2, d_aok2, d_dok2, m_req2, m_wr2;
  logic [31:0] i_rd2, d_rd2, m_addr2, m_wd2;
  logic [1:0]  m_sz2;
  logic [3:0]  m_ws2;
  logic        i_aok4, i_dok4, d_aok4, d_dok4, m_req4, m_wr4;
  logic [31:0] i_rd4, d_rd4, m_addr4, m_wd4;
  logic [1:0]  m_sz4;
  logic [3:0]  m_ws4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(2)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(1'b0), .inst_size(2'd2), .inst_wstrb(4'hF),
    .inst_addr(IA), .inst_wdata(IWD),
    .inst_addr_ok(i_aok2), .inst_data_ok(i_dok2), .inst_rdata(i_rd2),
    .data_req(data_req), .data_wr(1'b1), .data_size(2'd1), .data_wstrb(4'h3),
    .data_addr(DA), .data_wdata(DWD),
    .data_addr_ok(d_aok2), .data_data_ok(d_dok2), .data_rdata(d_rd2),
    .mem_req(m_req2), .mem_wr(m_wr2), .mem_size(m_sz2), .mem_wstrb(m_ws2),
    .mem_addr(m_addr2), .mem_wdata(m_wd2),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  sram_req_arbiter #(.OUTSTANDING(4)) u_dut4 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(1'b0), .inst_size(2'd2), .inst_wstrb(4'hF),
    .inst_addr(IA), .inst_wdata(IWD),
    .inst_addr_ok(i_aok4), .inst_data_ok(i_dok4), .inst_rdata(i_rd4),
    .data_req(data_req), .data_wr(1'b1), .data_size(2'd1), .data_wstrb(4'h3),
    .data_addr(DA), .data_wdata(DWD),
    .data_addr_ok(d_aok4), .data_data_ok(d_dok4), .data_rdata(d_rd4),
    .mem_req(m_req4), .mem_wr(m_wr4), .mem_size(m_sz4), .mem_wstrb(m_ws4),
    .mem_addr(m_addr4), .mem_wdata(m_wd4),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ir, dr, aok, dok, input logic [31:0] rd,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic eiaok, edaok, eidok, eddok);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rd;
    v.e_req = ereq; v.e_addr = eaddr;
    v.e_iaok = eiaok; v.e_daok = edaok; v.e_idok = eidok; v.e_ddok = eddok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drive right after the rising edge, then wait so outputs are settled
  // and sampled well before the next rising edge.
  task automatic drive(input logic rn, ir, dr, aok, dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    resetn = rn; inst_req = ir; data_req = dr;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    #3;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    //          ir dr ak dk rdata          req addr iaok daok idok ddok
    vecs[0]  = mk(1, 0, 1, 0, 32'h0,        1, IA, 1, 0, 0, 0); // single fetch
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,        0, IA, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h02800C0C, 0, IA, 0, 0, 1, 0);
    vecs[3]  = mk(1, 1, 1, 0, 32'h0,        1, DA, 0, 1, 0, 0); // contention
    vecs[4]  = mk(1, 0, 1, 0, 32'h0,        1, IA, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 32'h1111_2222,0, IA, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 1, 32'h3333_4444,0, IA, 0, 0, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 32'h0,        1, IA, 0, 0, 0, 0); // lock
    vecs[8]  = mk(1, 1, 0, 0, 32'h0,        1, IA, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0, 32'h0,        1, IA, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 1, 0, 32'h0,        1, IA, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 1, 0, 32'h0,        1, DA, 0, 1, 0, 0); // now full
    vecs[12] = mk(1, 0, 1, 0, 32'h0,        0, IA, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 1, 32'h5555_6666,0, IA, 0, 0, 1, 0); // pop while full
    vecs[14] = mk(1, 0, 1, 1, 32'h7777_8888,1, IA, 1, 0, 0, 1); // push+pop
    vecs[15] = mk(0, 0, 0, 1, 32'h9999_AAAA,0, IA, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 1, 32'hBBBB_CCCC,0, IA, 0, 0, 0, 0); // empty resp
    vecs[17] = mk(0, 1, 0, 0, 32'h0,        1, DA, 0, 0, 0, 0); // lock data
    vecs[18] = mk(1, 0, 1, 0, 32'h0,        0, DA, 0, 0, 0, 0); // dropped req
    vecs[19] = mk(1, 1, 1, 0, 32'h0,        1, DA, 0, 1, 0, 0);
    vecs[20] = mk(1, 0, 0, 1, 32'hCAFE_0001,1, IA, 0, 0, 0, 1);
    vecs[21] = mk(1, 0, 1, 0, 32'h0,        1, IA, 1, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 1, 32'hCAFE_0002,0, IA, 0, 0, 1, 0);

    // Reset state with every input asserted
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("rst mem_req",      {31'b0, m_req2}, 32'd0);
    chk("rst addr_ok",      {30'b0, i_aok2, d_aok2}, 32'd0);
    chk("rst data_ok",      {30'b0, i_dok2, d_dok2}, 32'd0);
    chk("rst mem_req dut4", {31'b0, m_req4}, 32'd0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
      chk($sformatf("v%0d mem_req", i),      {31'b0, m_req2}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d mem_addr", i),     m_addr2, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wr", i),       {31'b0, m_wr2}, {31'b0, vecs[i].e_addr == DA});
      chk($sformatf("v%0d mem_wdata", i),    m_wd2, (vecs[i].e_addr == DA) ? DWD : IWD);
      chk($sformatf("v%0d inst_addr_ok", i), {31'b0, i_aok2}, {31'b0, vecs[i].e_iaok});
      chk($sformatf("v%0d data_addr_ok", i), {31'b0, d_aok2}, {31'b0, vecs[i].e_daok});
      chk($sformatf("v%0d inst_data_ok", i), {31'b0, i_dok2}, {31'b0, vecs[i].e_idok});
      chk($sformatf("v%0d data_data_ok", i), {31'b0, d_dok2}, {31'b0, vecs[i].e_ddok});
      chk($sformatf("v%0d inst_rdata", i),   i_rd2, vecs[i].rdata);
      chk($sformatf("v%0d data_rdata", i),   d_rd2, vecs[i].rdata);
    end

    // Ordering I,D,I on the 4-deep instance
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("ord issue I0", {31'b0, i_aok4}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("ord issue D1", {31'b0, d_aok4}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("ord issue I2", {31'b0, i_aok4}, 32'd1);
    chk("ord dut2 full", {31'b0, m_req2}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0A0_0001);
    chk("ord resp0", {30'b0, i_dok4, d_dok4}, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0A0_0002);
    chk("ord resp1", {30'b0, i_dok4, d_dok4}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0A0_0003);
    chk("ord resp2", {30'b0, i_dok4, d_dok4}, 32'd2);
    chk("ord resp2 rdata", i_rd4, 32'hA0A0_0003);

    // Reset with two outstanding, then a stray response
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst2 second accepted", {31'b0, d_aok2}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("rst2 mem_req in reset", {31'b0, m_req2}, 32'd0);
    chk("rst2 data_ok in reset", {30'b0, i_dok2, d_dok2}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000);
    chk("stray data_ok dut2", {30'b0, i_dok2, d_dok2}, 32'd0);
    chk("stray data_ok dut4", {30'b0, i_dok4, d_dok4}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("post-rst issue 1", {31'b0, i_aok2}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("post-rst issue 2", {31'b0, d_aok2}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("post-rst full", {31'b0, m_req2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
